// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers steered by the hazard unit,
// with saturating stall/flush event counters for performance debug.
module pipe_stage_regs #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013,
  parameter int                CTRL_W    = 12,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic [31:0]       instrF,
  output logic [XLEN-1:0]   pcF,
  output logic [XLEN-1:0]   pcD,
  output logic [31:0]       instrD,
  output logic              validD,
  input  logic [XLEN-1:0]   rdata1D,
  input  logic [XLEN-1:0]   rdata2D,
  input  logic [XLEN-1:0]   immD,
  input  logic [4:0]        raddr1D,
  input  logic [4:0]        raddr2D,
  input  logic [4:0]        waddrD,
  input  logic [CTRL_W-1:0] ctrlD,
  output logic [XLEN-1:0]   pcE,
  output logic [XLEN-1:0]   rdata1E,
  output logic [XLEN-1:0]   rdata2E,
  output logic [XLEN-1:0]   immE,
  output logic [4:0]        raddr1E,
  output logic [4:0]        raddr2E,
  output logic [4:0]        waddrE,
  output logic [CTRL_W-1:0] ctrlE,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [XLEN-1:0]   pcf_q, pcf_d;
  logic [XLEN-1:0]   pcd_q, pcd_d;
  logic [31:0]       instrd_q, instrd_d;
  logic              validd_q, validd_d;
  logic [XLEN-1:0]   pce_q, pce_d;
  logic [XLEN-1:0]   rdata1e_q, rdata1e_d;
  logic [XLEN-1:0]   rdata2e_q, rdata2e_d;
  logic [XLEN-1:0]   imme_q, imme_d;
  logic [4:0]        raddr1e_q, raddr1e_d;
  logic [4:0]        raddr2e_q, raddr2e_d;
  logic [4:0]        waddre_q, waddre_d;
  logic [CTRL_W-1:0] ctrle_q, ctrle_d;
  logic              valide_q, valide_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  // PC next state: a taken branch voids any stall raised by the wrong-path instruction
  always_comb begin
    pcf_d = pcf_q;
    if (br_taken) begin
      pcf_d = br_target;
    end else if (StallF) begin
      pcf_d = pcf_q;
    end else begin
      pcf_d = pcf_q + XLEN'(32'd4);
    end
  end

  // IF/ID next state: flush beats stall
  always_comb begin
    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    validd_d = validd_q;
    if (FlushD) begin
      instrd_d = NOP_INSTR;
      pcd_d    = {XLEN{1'b0}};
      validd_d = 1'b0;
    end else if (StallD) begin
      instrd_d = instrd_q;
      pcd_d    = pcd_q;
      validd_d = validd_q;
    end else begin
      instrd_d = instrF;
      pcd_d    = pcf_q;
      validd_d = 1'b1;
    end
  end

  // ID/EX next state: never held, a load-use stall arrives here as a bubble
  always_comb begin
    pce_d     = pcd_q;
    rdata1e_d = rdata1D;
    rdata2e_d = rdata2D;
    imme_d    = immD;
    raddr1e_d = raddr1D;
    raddr2e_d = raddr2D;
    waddre_d  = waddrD;
    ctrle_d   = ctrlD;
    valide_d  = validd_q;
    if (FlushE) begin
      pce_d     = {XLEN{1'b0}};
      rdata1e_d = {XLEN{1'b0}};
      rdata2e_d = {XLEN{1'b0}};
      imme_d    = {XLEN{1'b0}};
      raddr1e_d = 5'd0;
      raddr2e_d = 5'd0;
      waddre_d  = 5'd0;
      ctrle_d   = {CTRL_W{1'b0}};
      valide_d  = 1'b0;
    end else begin
      valide_d  = validd_q;
    end
  end

  // Event counters: a stall hidden under a D flush is not counted as a stall
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && !FlushD) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (FlushD) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over all controls
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q       <= RESET_PC;
      pcd_q       <= {XLEN{1'b0}};
      instrd_q    <= NOP_INSTR;
      validd_q    <= 1'b0;
      pce_q       <= {XLEN{1'b0}};
      rdata1e_q   <= {XLEN{1'b0}};
      rdata2e_q   <= {XLEN{1'b0}};
      imme_q      <= {XLEN{1'b0}};
      raddr1e_q   <= 5'd0;
      raddr2e_q   <= 5'd0;
      waddre_q    <= 5'd0;
      ctrle_q     <= {CTRL_W{1'b0}};
      valide_q    <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      pcf_q       <= pcf_d;
      pcd_q       <= pcd_d;
      instrd_q    <= instrd_d;
      validd_q    <= validd_d;
      pce_q       <= pce_d;
      rdata1e_q   <= rdata1e_d;
      rdata2e_q   <= rdata2e_d;
      imme_q      <= imme_d;
      raddr1e_q   <= raddr1e_d;
      raddr2e_q   <= raddr2e_d;
      waddre_q    <= waddre_d;
      ctrle_q     <= ctrle_d;
      valide_q    <= valide_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pcF       = pcf_q;
  assign pcD       = pcd_q;
  assign instrD    = instrd_q;
  assign validD    = validd_q;
  assign pcE       = pce_q;
  assign rdata1E   = rdata1e_q;
  assign rdata2E   = rdata2e_q;
  assign immE      = imme_q;
  assign raddr1E   = raddr1e_q;
  assign raddr2E   = raddr2e_q;
  assign waddrE    = waddre_q;
  assign ctrlE     = ctrle_q;
  assign validE    = valide_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Consumer side of the hazard-control interface: the PC register, IF/ID register and ID/EX register of the 5-stage pipeline.
- Applies StallF/StallD/FlushD/FlushE and the branch redirect every cycle.
- Keeps saturating stall and flush event counters for performance debug.
- Sits between imem/decode and the execute stage; the hazard unit drives its control inputs.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding injected into IF/ID on flush or reset (addi x0,x0,0).
- CTRL_W, 12, width of the packed decode control bundle.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- StallF  in  1  hold the PC register.
- StallD  in  1  hold the IF/ID register.
- FlushD  in  1  load a bubble into IF/ID.
- FlushE  in  1  load a bubble into ID/EX.
- br_taken  in  1  branch resolved taken in E.
- br_target  in  XLEN  redirect address.
- instrF  in  32  instruction from imem at pcF.
- pcF  out  XLEN  current fetch PC.
- pcD, instrD, validD  out  XLEN/32/1  IF/ID contents.
- rdata1D, rdata2D, immD  in  XLEN each  decode operands.
- raddr1D, raddr2D, waddrD  in  5 each  decode register indices.
- ctrlD  in  CTRL_W  packed control: [0] reg_wr, [1] mem_wr, [3:2] wb_sel, [7:4] alu_op, [10:8] br_type, [11] sel_b.
- pcE, rdata1E, rdata2E, immE  out  XLEN each  ID/EX data.
- raddr1E, raddr2E, waddrE  out  5 each  ID/EX indices, fed back to the hazard unit.
- ctrlE  out  CTRL_W  ID/EX control.
- validE  out  1  ID/EX holds a real instruction.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- All state updates on posedge clk.
- rst has priority over everything. On reset:
  - pcF=RESET_PC; instrD=NOP_INSTR; pcD=0; validD=0.
  - All E data/index outputs=0; ctrlE=0; validE=0.
  - stall_cnt=0; flush_cnt=0.
- PC register, priority order:
  - br_taken: pcF<=br_target. Overrides StallF, because a stall caused by a wrong-path D instruction is void.
  - else StallF: hold.
  - else pcF<=pcF+4, wrapping modulo 2^XLEN.
- IF/ID register, priority order:
  - FlushD: instrD<=NOP_INSTR, pcD<=0, validD<=0. Flush wins over StallD.
  - else StallD: hold all fields.
  - else instrD<=instrF, pcD<=pcF, validD<=1.
- ID/EX register:
  - FlushE: ctrlE<=0, validE<=0, waddrE/raddr1E/raddr2E<=0. Data fields may be loaded or zeroed; they must be 0 in this implementation.
  - else load every D-side input, and validE<=validD.
  - ID/EX is never stalled. A load-use stall is expressed only as FlushE.
- Latency: an instruction presented at instrF with no hazards appears on instrD 1 cycle later and on the E outputs 2 cycles later.
- Counters:
  - stall_cnt +1 on each cycle with StallD=1 and FlushD=0.
  - flush_cnt +1 on each cycle with FlushD=1.
  - Both saturate at all-ones and do not wrap.
  - Counters are not cleared by flushes.
- Simultaneous StallF+StallD+FlushE (load-use): PC and IF/ID hold; ID/EX gets a bubble. The instruction in D re-enters ID/EX on the next non-flushed cycle.
- Simultaneous br_taken+FlushD+FlushE with stalls also asserted: PC redirects; IF/ID and ID/EX both bubble; flush_cnt increments; stall_cnt does not.
- rst asserted mid-stall or mid-flush: reset values next cycle; no pending stall or redirect survives.

Test Plan:
- Reset then free-run, instrF=0x00500093 constant, no hazards -> pcF=0,4,8,12; instrD=0x00500093 and validD=1 from cycle 2; validE=1 from cycle 3.
- Load-use: StallF=StallD=FlushE=1 for one cycle at pcF=0x10 -> pcF holds 0x10, then 0x14; instrD held; ctrlE=0 and validE=0 for that cycle; stall_cnt=1.
- Branch: br_taken=1, br_target=0x200, FlushD=FlushE=1 at pcF=0x24 -> next pcF=0x200; instrD=0x00000013; validD=0; ctrlE=0; flush_cnt=1.
- Branch plus stall same cycle (all five controls high, target 0x80) -> pcF=0x80, not held; IF/ID bubbled; stall_cnt unchanged; flush_cnt+1.
- PC wrap: force pcF to 0xFFFF_FFFC via br_target, then free-run -> next pcF=0x0000_0000.
- Counter saturation with CNT_W=4: hold StallD=1 for 20 cycles -> stall_cnt reaches 15 and stays; rst mid-sequence -> counters 0, pcF=RESET_PC next cycle.
